// File: rtl/ring_pkg.sv
// Shared constants and helpers for the parametrised ring/Johnson counter.
// Imported by the legality checker and the counter top.
package ring_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;
   localparam logic DIR_LEFT     = 1'b0;
   localparam logic DIR_RIGHT    = 1'b1;

   // Widest counter the seed helper can describe; callers cast down to WIDTH.
   localparam int SEED_MAX_WIDTH = 1024;

   // Seed state: a single one in the LSB, legal in both ring and Johnson modes.
   function automatic logic [SEED_MAX_WIDTH-1:0] seed_of(input int width);
      logic [SEED_MAX_WIDTH-1:0] seed;
      seed = '0;
      if (width >= 1) seed[0] = 1'b1;
      return seed;
   endfunction

endpackage : ring_pkg

// File: rtl/ring_legal_chk.sv
// Combinational legality test for a ring/Johnson counter state.
// Ring: exactly one bit set. Johnson: at most one boundary between adjacent bits.
module ring_legal_chk
   import ring_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] Q,
   input  logic             mode,
   output logic             legal
);

   // Each set bit marks a 0/1 boundary between neighbours; a thermometer has at most one.
   logic [WIDTH-2:0] edges;

   assign edges = Q[WIDTH-2:0] ^ Q[WIDTH-1:1];

   always_comb begin
      if (mode == MODE_RING) legal = ($countones(Q) == 1);
      else                   legal = ($countones(edges) <= 1);
   end

endmodule : ring_legal_chk

// File: rtl/ring_counter_n.sv
// WIDTH-bit ring / Johnson shift counter with direction, enable, parallel load,
// one-step correction of illegal states, and registered wrap/fix pulses.
module ring_counter_n
   import ring_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] Q,
   output logic             legal,
   output logic             wrap,
   output logic             fix
);

   localparam logic [WIDTH-1:0] SEED = WIDTH'(seed_of(WIDTH));

   if (WIDTH < 2) begin : g_bad_width
      $error("ring_counter_n: WIDTH must be at least 2");
   end

   logic [WIDTH-1:0] next_q;

   ring_legal_chk #(
      .WIDTH (WIDTH)
   ) u_legal (
      .Q     (Q),
      .mode  (mode),
      .legal (legal)
   );

   // The Johnson variants feed back the inverted outgoing bit; ring feeds it back as-is.
   always_comb begin
      next_q = Q;
      if (dir == DIR_LEFT) begin
         if (mode == MODE_RING) next_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
         else                   next_q = {Q[WIDTH-2:0], ~Q[WIDTH-1]};
      end else begin
         if (mode == MODE_RING) next_q = {Q[0], Q[WIDTH-1:1]};
         else                   next_q = {~Q[0], Q[WIDTH-1:1]};
      end
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         Q    <= SEED;
         wrap <= 1'b0;
         fix  <= 1'b0;
      end else if (load) begin
         Q    <= din;
         wrap <= 1'b0;
         fix  <= 1'b0;
      end else if (en) begin
         if (legal) begin
            Q    <= next_q;
            wrap <= (next_q == SEED);
            fix  <= 1'b0;
         end else begin
            // Illegal states snap straight back to the seed rather than walking out.
            Q    <= SEED;
            wrap <= 1'b0;
            fix  <= 1'b1;
         end
      end else begin
         wrap <= 1'b0;
         fix  <= 1'b0;
      end
   end

endmodule : ring_counter_n

// File: tb/tb_ring_counter_n.sv
// Self-checking bench for ring_counter_n (WIDTH=8): directed vector table,
// hand-written corner sequences, then randomized traffic against a sequence-list model.
module tb_ring_counter_n;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         clear;
   logic         en;
   logic         mode;
   logic         dir;
   logic         load;
   logic [W-1:0] din;
   logic [W-1:0] Q;
   logic         legal;
   logic         wrap;
   logic         fix;

   int checks = 0;
   int errors = 0;

   ring_counter_n #(
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .clear (clear),
      .en    (en),
      .mode  (mode),
      .dir   (dir),
      .load  (load),
      .din   (din),
      .Q     (Q),
      .legal (legal),
      .wrap  (wrap),
      .fix   (fix)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic check_all(input string tag, input logic [W-1:0] q_e, input logic wrap_e,
                            input logic fix_e, input logic legal_e);
      check({tag, ".Q"},     32'(Q),     32'(q_e));
      check({tag, ".wrap"},  32'(wrap),  32'(wrap_e));
      check({tag, ".fix"},   32'(fix),   32'(fix_e));
      check({tag, ".legal"}, 32'(legal), 32'(legal_e));
   endtask

   task automatic drive(input logic ld, input logic e, input logic m, input logic d,
                        input logic [W-1:0] value);
      load = ld;
      en   = e;
      mode = m;
      dir  = d;
      din  = value;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // Legal states are the members of the mode's cyclic sequence; counting moves one
   // position forward (left) or backward (right) along that list.
   function automatic int period(input logic m);
      return m ? 2 * W : W;
   endfunction

   function automatic logic [W-1:0] seq_state(input logic m, input int idx);
      int v;
      if (!m)          v = 1 << idx;
      else if (idx < W) v = (1 << (idx + 1)) - 1;
      else             v = ((1 << W) - 1) & ~((1 << (idx - W + 1)) - 1);
      return W'(v);
   endfunction

   function automatic int find_idx(input logic [W-1:0] q, input logic m);
      for (int i = 0; i < period(m); i++)
         if (seq_state(m, i) == q) return i;
      return -1;
   endfunction

   logic [W-1:0] m_q;
   logic         m_wrap;
   logic         m_fix;

   task automatic model_reset();
      m_q    = 8'h01;
      m_wrap = 1'b0;
      m_fix  = 1'b0;
   endtask

   task automatic model_step();
      int idx;
      int p;
      if (load) begin
         m_q = din; m_wrap = 1'b0; m_fix = 1'b0;
      end else if (en) begin
         idx = find_idx(m_q, mode);
         p   = period(mode);
         if (idx < 0) begin
            m_q = 8'h01; m_wrap = 1'b0; m_fix = 1'b1;
         end else begin
            m_q    = seq_state(mode, dir ? (idx + p - 1) % p : (idx + 1) % p);
            m_wrap = (m_q == 8'h01);
            m_fix  = 1'b0;
         end
      end else begin
         m_wrap = 1'b0; m_fix = 1'b0;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic         load;
      logic         en;
      logic         mode;
      logic         dir;
      logic [W-1:0] din;
      logic [W-1:0] q;
      logic         wrap;
      logic         fix;
      logic         legal;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic ld, input logic e, input logic m, input logic d,
                               input logic [W-1:0] dv, input logic [W-1:0] q,
                               input logic wr, input logic fx, input logic lg);
      vec_t v;
      v.load = ld; v.en = e; v.mode = m; v.dir = d; v.din = dv;
      v.q = q; v.wrap = wr; v.fix = fx; v.legal = lg;
      vecs.push_back(v);
   endfunction

   logic [W-1:0] ring_l[8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
   logic [W-1:0] john_l[16] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
                                8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
   logic [W-1:0] ring_r[8]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   initial begin
      clear = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      #12;
      check_all("reset", 8'h01, 1'b0, 1'b0, 1'b1);
      clear = 1'b0;

      for (int i = 0; i < 8; i++)  add(0, 1, 0, 0, 0, ring_l[i], i == 7, 0, 1);
      add(0, 0, 0, 0, 0, 8'h01, 0, 0, 1);
      for (int i = 0; i < 16; i++) add(0, 1, 1, 0, 0, john_l[i], i == 15, 0, 1);
      for (int i = 0; i < 8; i++)  add(0, 1, 0, 1, 0, ring_r[i], i == 7, 0, 1);
      for (int i = 0; i < 4; i++)  add(0, 1, 0, 1, 0, ring_r[i], 0, 0, 1);
      add(0, 1, 0, 0, 0, 8'h20, 0, 0, 1);
      add(0, 1, 0, 0, 0, 8'h40, 0, 0, 1);
      add(0, 1, 0, 0, 0, 8'h80, 0, 0, 1);
      add(0, 1, 0, 0, 0, 8'h01, 1, 0, 1);

      foreach (vecs[i]) begin
         drive(vecs[i].load, vecs[i].en, vecs[i].mode, vecs[i].dir, vecs[i].din);
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].wrap, vecs[i].fix, vecs[i].legal);
      end

      // Load an illegal ring value, hold it, then correct it in one step.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h05);
      tick();
      check_all("load05", 8'h05, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         tick();
         check_all($sformatf("hold05_%0d", i), 8'h05, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      check_all("fix05", 8'h01, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      check_all("fix_pulse_end", 8'h01, 1'b0, 1'b0, 1'b1);

      // Johnson state that is illegal as a ring state, then mode switch.
      drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      check_all("john03", 8'h03, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      #1;
      check("ring03_legal", 32'(legal), 32'h0);
      tick();
      check_all("ring03_fix", 8'h01, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h0F);
      tick();
      check_all("load0F", 8'h0F, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      check_all("john1F", 8'h1F, 1'b0, 1'b0, 1'b1);

      // Load of SEED gives no wrap; count to 0x40 then clear mid-cycle.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
      tick();
      check_all("load_seed", 8'h01, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         tick();
      end
      check_all("at40", 8'h40, 1'b0, 1'b0, 1'b1);
      #2;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
      clear = 1'b1;
      #1;
      check_all("clear_async", 8'h01, 1'b0, 1'b0, 1'b1);
      tick();
      check_all("clear_held", 8'h01, 1'b0, 1'b0, 1'b1);
      #2;
      clear = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      check_all("after_clear", 8'h02, 1'b0, 1'b0, 1'b1);

      // ---------------- randomized traffic vs model ----------------
      #2;
      clear = 1'b1;
      model_reset();
      #1;
      clear = 1'b0;
      for (int i = 0; i < 600; i++) begin
         logic m_sel;
         m_sel = 1'($urandom);
         drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 9) == 0) ? ~mode : mode,
               ($urandom_range(0, 7) == 0) ? ~dir : dir,
               $urandom_range(0, 1) ? W'($urandom)
                                    : seq_state(m_sel, $urandom_range(0, period(m_sel) - 1)));
         model_step();
         tick();
         check_all($sformatf("rand%0d", i), m_q, m_wrap, m_fix, find_idx(m_q, mode) >= 0);
         if ($urandom_range(0, 49) == 0) begin
            #2;
            clear = 1'b1;
            model_reset();
            #1;
            check_all($sformatf("rand_clear%0d", i), m_q, m_wrap, m_fix, 1'b1);
            clear = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_ring_counter_n
